// File: rtl/serial_sub4bit.sv
// Bit-serial 4-bit subtractor computing a - b - Bin one bit per clock, LSB first,
// behind a start/busy/done handshake; difference, final borrow and signed overflow are registered.
module serial_sub4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       Bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] d,
  output logic       bout,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       br_q;
  logic [3:0] res_q;
  logic [1:0] cnt_q;
  logic       sa_q;
  logic       sb_q;
  logic       busy_q;
  logic       done_q;
  logic [3:0] d_q;
  logic       bout_q;
  logic       ovf_q;

  logic       x_d;
  logic       y_d;
  logic       diff_bit_d;
  logic       borrow_d;
  logic [3:0] res_d;
  logic       ovf_d;

  // One full-subtractor step on the current LSBs plus the result it would complete
  always_comb begin
    x_d        = a_q[0];
    y_d        = b_q[0];
    diff_bit_d = x_d ^ y_d ^ br_q;
    borrow_d   = (~x_d & y_d) | (~(x_d ^ y_d) & br_q);
    res_d      = {diff_bit_d, res_q[3:1]};
    ovf_d      = (sa_q ^ sb_q) & (res_d[3] ^ sa_q);
  end

  // Control FSM, datapath shift registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 4'b0000;
      b_q     <= 4'b0000;
      br_q    <= 1'b0;
      res_q   <= 4'b0000;
      cnt_q   <= 2'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= 4'b0000;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= Bin;
            res_q   <= 4'b0000;
            cnt_q   <= 2'd0;
            sa_q    <= a[3];
            sb_q    <= b[3];
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= {1'b0, a_q[3:1]};
          b_q   <= {1'b0, b_q[3:1]};
          br_q  <= borrow_d;
          res_q <= res_d;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            d_q     <= res_d;
            bout_q  <= borrow_d;
            ovf_q   <= ovf_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign d        = d_q;
  assign bout     = bout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_sub4bit.sv
// Self-checking bench for serial_sub4bit: arithmetic reference model checked every cycle,
// plus hand-computed expectations for each directed vector.
module tb_serial_sub4bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = 4'b0000;
  logic [3:0] b = 4'b0000;
  logic       Bin = 1'b0;
  logic       busy;
  logic       done;
  logic [3:0] d;
  logic       bout;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  // Hand-computed expectation for the operation currently in flight
  logic [3:0] lit_d = 4'b0000;
  logic       lit_bout = 1'b0;
  logic       lit_ovf = 1'b0;

  // Reference model state
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [3:0] m_d = 4'b0000;
  logic       m_bout = 1'b0;
  logic       m_ovf = 1'b0;
  int         m_left = 0;
  logic [5:0] m_pend = 6'd0;

  serial_sub4bit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .Bin(Bin),
    .busy(busy), .done(done), .d(d), .bout(bout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Plain integer arithmetic: returns {overflow, bout, d}
  function automatic logic [5:0] ref_sub(input logic [3:0] ua, input logic [3:0] ub, input logic bi);
    int diff;
    int sdiff;
    logic [3:0] dd;
    logic bo;
    logic ov;
    diff  = int'(ua) - int'(ub) - int'(bi);
    sdiff = int'($signed(ua)) - int'($signed(ub)) - int'(bi);
    bo    = (diff < 0);
    dd    = 4'((diff + 16) % 16);
    ov    = (sdiff < -8) || (sdiff > 7);
    return {ov, bo, dd};
  endfunction

  // Cycle model: 4 cycles busy after acceptance, then one done cycle carrying the result
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_d    <= 4'b0000;
      m_bout <= 1'b0;
      m_ovf  <= 1'b0;
      m_left <= 0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_d    <= m_pend[3:0];
        m_bout <= m_pend[4];
        m_ovf  <= m_pend[5];
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_busy <= 1'b1;
        m_left <= 4;
        m_pend <= ref_sub(a, b, Bin);
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: away from clock edges and just after any reset assertion
  always begin
    @(negedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      chk("rst_busy", {3'b000, busy}, 4'b0000);
      chk("rst_done", {3'b000, done}, 4'b0000);
      chk("rst_d", d, 4'b0000);
      chk("rst_bout", {3'b000, bout}, 4'b0000);
      chk("rst_ovf", {3'b000, overflow}, 4'b0000);
    end else begin
      chk("busy", {3'b000, busy}, {3'b000, m_busy});
      chk("done", {3'b000, done}, {3'b000, m_done});
      chk("d", d, m_d);
      chk("bout", {3'b000, bout}, {3'b000, m_bout});
      chk("ovf", {3'b000, overflow}, {3'b000, m_ovf});
      if (m_done) begin
        chk("lit_d", d, lit_d);
        chk("lit_bout", {3'b000, bout}, {3'b000, lit_bout});
        chk("lit_ovf", {3'b000, overflow}, {3'b000, lit_ovf});
        chk("model_d", m_d, lit_d);
        chk("model_flags", {2'b00, m_ovf, m_bout}, {2'b00, lit_ovf, lit_bout});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic set_op(input logic [3:0] va, input logic [3:0] vb, input logic vbi,
                        input logic [3:0] ed, input logic eb, input logic eo);
    a = va; b = vb; Bin = vbi;
    lit_d = ed; lit_bout = eb; lit_ovf = eo;
  endtask

  task automatic run_op(input logic [3:0] va, input logic [3:0] vb, input logic vbi,
                        input logic [3:0] ed, input logic eb, input logic eo);
    set_op(va, vb, vbi, ed, eb, eo);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    a = ~va; b = ~vb; Bin = ~vbi;
    cyc(5);
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    run_op(4'b1010, 4'b1010, 1'b1, 4'b1111, 1'b1, 1'b0);
    run_op(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    run_op(4'b0111, 4'b1010, 1'b1, 4'b1100, 1'b1, 1'b1);
    run_op(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);
    run_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);

    // Ignored start mid-run, then start held so the next op is accepted in the done cycle
    set_op(4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    start = 1'b1;
    a = 4'b1111;
    cyc(1);
    start = 1'b0;
    a = 4'b1100; b = 4'b0011; Bin = 1'b1;
    cyc(1);
    start = 1'b1;
    cyc(1);
    lit_d = 4'b1000; lit_bout = 1'b0; lit_ovf = 1'b0;
    cyc(1);
    start = 1'b0;
    a = 4'b0000; b = 4'b1111; Bin = 1'b0;
    cyc(5);

    // Reset during the second run cycle discards the operation
    set_op(4'b0110, 4'b0001, 1'b0, 4'b0101, 1'b0, 1'b0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(6);

    run_op(4'b1111, 4'b0000, 1'b1, 4'b1110, 1'b0, 1'b0);
    run_op(4'b0011, 4'b1101, 1'b0, 4'b0110, 1'b1, 1'b0);
    run_op(4'b0100, 4'b1011, 1'b1, 4'b1000, 1'b1, 1'b1);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_sub4bit.md
# serial_sub4bit

Bit-serial 4-bit subtractor with borrow-in, the sequential counterpart to the team's combinational 4-bit ripple adder. It computes `a - b - Bin` one bit per clock, LSB first, through a start/busy/done handshake. It reports the 4-bit difference, the final borrow and signed overflow. It serves as the subtract path in multi-cycle datapaths where area matters more than latency.

## Interface
- No parameters; width fixed at 4 bits.
- `clk  input  1` — single clock; all state changes on its rising edge.
- `rst_n  input  1` — asynchronous, active-low reset.
- `start  input  1` — request; sampled on a rising edge, accepted only in IDLE or DONE.
- `a  input  4` — minuend; captured on the accepting edge.
- `b  input  4` — subtrahend; captured on the accepting edge.
- `Bin  input  1` — borrow-in; captured on the accepting edge.
- `busy  output  1` — high while in RUN.
- `done  output  1` — high for exactly one cycle (state DONE).
- `d  output  4` — difference, `(a - b - Bin) mod 16`.
- `bout  output  1` — final unsigned borrow: 1 iff `a < b + Bin`.
- `overflow  output  1` — signed (two's complement) overflow: `a[3] != b[3]` and `d[3] != a[3]`.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- **IDLE**
  - `start` = 1: capture `a`, `b`, `Bin` into internal shift/borrow registers, clear the bit counter to 0, go to RUN.
  - Otherwise remain in IDLE.
- **RUN**, one bit per edge, with `x` = current LSB of the A shift register, `y` = current LSB of the B shift register, `br` = borrow register:
  - Difference bit: `x ^ y ^ br`.
  - Next borrow: `(~x & y) | (~(x ^ y) & br)`.
  - Shift A and B right.
  - Shift the difference bit into the internal result register from the MSB side.
  - Increment the counter.
- **Exit from RUN**: on the edge that processes bit 3 (counter = 3):
  - Load `d` from the completed result.
  - Load `bout` from the final borrow.
  - Compute `overflow` from the captured sign bits `a[3]`, `b[3]` and the new `d[3]`.
  - Go to DONE.
- **DONE**: `done` = 1.
  - `start` = 1: accept a new operation exactly as in IDLE, go to RUN (back-to-back operation).
  - Otherwise return to IDLE.
- `start` in RUN is ignored: no capture, no effect on the operation in flight.
- `d`, `bout` and `overflow` change only on the DONE-entry edge. They hold their values through IDLE and through any following RUN until the next completion.
- Input changes on `a`, `b`, `Bin` after the accepting edge have no effect.

## Timing
- Reset values: state IDLE, `busy` = 0, `done` = 0, `d` = 4'b0000, `bout` = 0, `overflow` = 0. All internal registers are cleared.
- `rst_n` low at any time, including mid-RUN: outputs and state go to their reset values immediately (asynchronous). The operation in flight is discarded; no `done` is produced for it.
- Latency, with `start` accepted at edge E0:
  - `busy` is high from just after E0 until just after E4.
  - Edges E1–E4 process bits 0–3.
  - `d`, `bout` and `overflow` are valid and `done` = 1 in the cycle after E4.
  - Total: 4 cycles from accept to result and `done`.
- Throughput: with `start` held high, one result every 5 cycles (accept, 4 × RUN, DONE/accept).
- `busy` and `done` are never high simultaneously. `done` is never high for 2 consecutive cycles.

## Test plan
- Reset, then `a` = 4'b1010, `b` = 4'b1010, `Bin` = 1, pulse `start` -> after 4 cycles `done` = 1, `d` = 4'b1111, `bout` = 1, `overflow` = 0.
- `a` = 4'b0000, `b` = 4'b0000, `Bin` = 0 -> `d` = 4'b0000, `bout` = 0, `overflow` = 0; `busy` high exactly 4 cycles.
- `a` = 4'b0111, `b` = 4'b1010, `Bin` = 1 -> `d` = 4'b1100, `bout` = 1, `overflow` = 1.
- `a` = 4'b1000, `b` = 4'b0001, `Bin` = 0 -> `d` = 4'b0111, `bout` = 0, `overflow` = 1.
- Start with `a` = 4'b0101, `b` = 4'b0011, `Bin` = 0:
  - Mid-RUN, pulse `start` with `a` = 4'b1111 -> it is ignored; `d` = 4'b0010, `bout` = 0, `overflow` = 0.
  - Then hold `start` high -> the next operation is accepted in the DONE cycle.
- Assert `rst_n` low during the second RUN cycle -> all outputs 0 immediately and no `done` pulse. A new `start` after release completes normally.
